// File: rtl/dtree_eval_sched.sv
// ---------------------------------------------------------------------------
// dtree_eval_sched
//
// Sequencer in front of an external, purely combinational decision-tree
// classifier. It gathers one feature vector from a serial valid/ready beat
// stream into a register bank and drives that bank onto the tree's input
// bus. The bus is held stable for SETTLE_CYC cycles, and then the tree's
// class output is captured and offered on a valid/ready result port.
// Only one sample is in flight at a time: loading and result holding never
// overlap.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  feature beat handshake; beat k carries feature index k
//   in_feat         feature value (FEAT_W bits)
//   in_last         marks the final beat of a sample
//   feat_bus        registered features to the tree, feature k at
//                   [k*FEAT_W +: FEAT_W]
//   tree_class      combinational class returned by the tree
//   out_valid/ready result handshake
//   out_class       captured class
//   err_frame       one-cycle pulse after a beat that breaks framing
//
// Optional build macro DTREE_EVAL_SCHED_STATS_EN adds two saturating 16-bit
// counters: cnt_samples (result handshakes) and cnt_errors (err_frame pulses).
// ---------------------------------------------------------------------------
module dtree_eval_sched #(
   parameter int NUM_FEAT   = 16,
   parameter int FEAT_W     = 8,
   parameter int CLASS_W    = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [FEAT_W-1:0]           in_feat,
   input  logic                        in_last,
   output logic [NUM_FEAT*FEAT_W-1:0]  feat_bus,
   input  logic [CLASS_W-1:0]          tree_class,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CLASS_W-1:0]          out_class,
   output logic                        err_frame
`ifdef DTREE_EVAL_SCHED_STATS_EN
   ,
   output logic [15:0]                 cnt_samples,
   output logic [15:0]                 cnt_errors
`endif
);

   localparam int IDX_W = $clog2(NUM_FEAT);
   // A one-cycle settle window still needs a 1-bit counter.
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_DISCARD,
      S_SETTLE,
      S_HOLD
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [NUM_FEAT*FEAT_W-1:0]   feat_q, feat_d;
   logic                         out_valid_q, out_valid_d;
   logic [CLASS_W-1:0]           out_class_q, out_class_d;
   logic                         err_q, err_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      feat_d      = feat_q;
      out_valid_d = out_valid_q;
      out_class_d = out_class_q;
      err_d       = 1'b0;
      in_ready    = 1'b0;

      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Every accepted beat is written, even one that breaks
               // framing; stale slots are overwritten by the next frame.
               feat_d[int'(idx_q)*FEAT_W +: FEAT_W] = in_feat;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  if (in_last) begin
                     state_d = S_SETTLE;
                     cnt_d   = '0;
                  end else begin
                     // Frame too long: drop the remainder up to in_last.
                     err_d   = 1'b1;
                     state_d = S_DISCARD;
                  end
               end else if (in_last) begin
                  // Frame too short: restart collection without a result.
                  err_d = 1'b1;
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         S_DISCARD: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_d = S_LOAD;
            end
         end

         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               out_class_d = tree_class;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_LOAD;
            end
         end

         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         idx_q       <= '0;
         cnt_q       <= '0;
         feat_q      <= '0;
         out_valid_q <= 1'b0;
         out_class_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         feat_q      <= feat_d;
         out_valid_q <= out_valid_d;
         out_class_q <= out_class_d;
         err_q       <= err_d;
      end
   end

   assign feat_bus  = feat_q;
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign err_frame = err_q;

`ifdef DTREE_EVAL_SCHED_STATS_EN
   logic [15:0] cnt_samples_q, cnt_samples_d;
   logic [15:0] cnt_errors_q, cnt_errors_d;

   // Counters advance on the same edge that completes the handshake or
   // raises err_frame, and stick at all-ones.
   always_comb begin
      cnt_samples_d = cnt_samples_q;
      cnt_errors_d  = cnt_errors_q;
      if ((state_q == S_HOLD) && out_ready && (cnt_samples_q != 16'hFFFF)) begin
         cnt_samples_d = cnt_samples_q + 16'd1;
      end
      if (err_d && (cnt_errors_q != 16'hFFFF)) begin
         cnt_errors_d = cnt_errors_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_samples_q <= '0;
         cnt_errors_q  <= '0;
      end else begin
         cnt_samples_q <= cnt_samples_d;
         cnt_errors_q  <= cnt_errors_d;
      end
   end

   assign cnt_samples = cnt_samples_q;
   assign cnt_errors  = cnt_errors_q;
`endif

endmodule

// File: tb/tb_dtree_eval_sched.sv
// ---------------------------------------------------------------------------
// Testbench for dtree_eval_sched. A frame-level reference model follows the
// beat stream and result handshakes; a compare process checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations for latency, feature placement, classes and error counts.
// ---------------------------------------------------------------------------
module tb_dtree_eval_sched;
   localparam int NF = 16;
   localparam int FW = 8;
   localparam int CW = 4;
   localparam int SC = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              out_ready = 1'b0;
   logic [FW-1:0]     in_feat = '0;
   logic [CW-1:0]     tree_class = '0;
   logic              in_ready;
   logic              out_valid;
   logic              err_frame;
   logic [NF*FW-1:0]  feat_bus;
   logic [CW-1:0]     out_class;
`ifdef DTREE_EVAL_SCHED_STATS_EN
   logic [15:0]       cnt_samples;
   logic [15:0]       cnt_errors;
`endif

   dtree_eval_sched #(
      .NUM_FEAT(NF), .FEAT_W(FW), .CLASS_W(CW), .SETTLE_CYC(SC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat), .in_last(in_last),
      .feat_bus(feat_bus), .tree_class(tree_class),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .err_frame(err_frame)
`ifdef DTREE_EVAL_SCHED_STATS_EN
      , .cnt_samples(cnt_samples), .cnt_errors(cnt_errors)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;   // number of rising edges seen so far

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [NF*FW-1:0] act,
                      input logic [NF*FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [FW-1:0] m_feat [NF];
   logic [CW-1:0] m_class = '0;
   int            m_pos  = 0;
   int            m_due  = 0;
   bit            m_drop = 0;   // inside an over-long frame
   bit            m_busy = 0;   // a complete sample is settling or waiting
   bit            m_resv = 0;   // result on offer
   bit            m_err  = 0;

   initial for (int k = 0; k < NF; k++) m_feat[k] = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NF; k++) m_feat[k] = '0;
         m_class = '0; m_pos = 0; m_due = 0;
         m_drop = 0; m_busy = 0; m_resv = 0; m_err = 0;
      end else begin
         int edge_no;
         edge_no = cyc + 1;
         m_err = 0;
         if (m_busy) begin
            if (m_resv) begin
               if (out_ready) begin
                  m_resv = 0;
                  m_busy = 0;
               end
            end else if (edge_no == m_due) begin
               m_resv  = 1;
               m_class = tree_class;
            end
         end else if (in_valid) begin
            if (m_drop) begin
               if (in_last) m_drop = 0;
            end else begin
               m_feat[m_pos] = in_feat;
               if (m_pos == NF - 1) begin
                  m_pos = 0;
                  if (in_last) begin
                     m_busy = 1;
                     m_due  = edge_no + SC;
                  end else begin
                     m_err  = 1;
                     m_drop = 1;
                  end
               end else if (in_last) begin
                  m_err = 1;
                  m_pos = 0;
               end else begin
                  m_pos++;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [NF*FW-1:0] exp_bus;
   always @(negedge clk) begin
      for (int k = 0; k < NF; k++) exp_bus[k*FW +: FW] = m_feat[k];
      chk("cyc_in_ready",  in_ready,  !m_busy);
      chk("cyc_out_valid", out_valid, m_resv);
      chk("cyc_out_class", out_class, m_class);
      chk("cyc_err_frame", err_frame, m_err);
      chk("cyc_feat_bus",  feat_bus,  exp_bus);
   end

   // ---------------- event monitors ----------------
   int   err_seen = 0;
   int   ov_rise  = 0;
   logic ov_prev  = 1'b0;
   always @(negedge clk) begin
      if (err_frame) err_seen <= err_seen + 1;
      if (out_valid && !ov_prev) ov_rise <= ov_rise + 1;
      ov_prev <= out_valid;
   end

   // ---------------- drivers ----------------
   int t_last = 0;

   task automatic beat(input logic [FW-1:0] f, input bit l);
      int w;
      w = 0;
      in_valid = 1'b1; in_feat = f; in_last = l;
      while (!in_ready && w < 100) begin
         @(negedge clk); #1; w++;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL beat_accept: in_ready stuck at 0, required 1 within 100 cycles");
      end
      @(negedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (l) t_last = cyc;
   endtask

   task automatic frame(input int n, input int last_at, input logic [FW-1:0] base);
      for (int k = 0; k < n; k++) beat(base + FW'(k), (k == last_at));
   endtask

   task automatic get_result(input logic [CW-1:0] exp_cls, input int hold);
      int w;
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk); #1; w++;
      end
      if (!out_valid) begin
         n_checks++; n_fail++;
         $display("FAIL result_timeout: out_valid stayed 0, required 1 within 50 cycles");
         return;
      end
      chk("latency", cyc - t_last, 2);
      chk("out_class", out_class, exp_cls);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_class", out_class, exp_cls);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk); #1;
      out_ready = 1'b0;
      chk("post_hs_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int e0, r0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_feat_bus",  feat_bus, 0);
      chk("rst_err_frame", err_frame, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rel_in_ready", in_ready, 1);

      // Nominal frame, then 10 cycles of back-pressure on the result.
      tree_class = 4'd7;
      frame(16, 15, 8'h10);
      for (int k = 0; k < NF; k++) chk("nom_feat", feat_bus[k*FW +: FW], 8'h10 + k);
      get_result(4'd7, 10);
      chk("nom_no_err", err_seen, 0);

      // Second frame immediately after the handshake.
      tree_class = 4'd3;
      frame(16, 15, 8'h40);
      get_result(4'd3, 0);

      // Reset while the bus is settling.
      tree_class = 4'd5;
      r0 = ov_rise;
      frame(16, 15, 8'h20);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_feat_bus", feat_bus, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
      end
      chk("midrst_no_result", ov_rise - r0, 0);
      chk("midrst_ready_after", in_ready, 1);
      tree_class = 4'd9;
      frame(16, 15, 8'h30);
      get_result(4'd9, 0);

      // Short frame: in_last on beat 5.
      e0 = err_seen; r0 = ov_rise;
      frame(6, 5, 8'h50);
      repeat (4) begin
         @(negedge clk); #1;
      end
      chk("short_err_once", err_seen - e0, 1);
      chk("short_no_result", ov_rise - r0, 0);
      tree_class = 4'd2;
      frame(16, 15, 8'h60);
      get_result(4'd2, 0);

      // Long frame: 20 beats, in_last on beat 19.
      e0 = err_seen; r0 = ov_rise;
      frame(20, 19, 8'h70);
      repeat (4) begin
         @(negedge clk); #1;
      end
      chk("long_err_once", err_seen - e0, 1);
      chk("long_no_result", ov_rise - r0, 0);
      chk("long_feat15", feat_bus[15*FW +: FW], 8'h7F);
      tree_class = 4'd11;
      frame(16, 15, 8'h80);
      chk("model_feat3", m_feat[3], 8'h83);
      get_result(4'd11, 0);
      chk("model_class", m_class, 4'd11);

`ifdef DTREE_EVAL_SCHED_STATS_EN
      chk("stats_samples", cnt_samples, 16'd3);
      chk("stats_errors",  cnt_errors,  16'd2);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dtree_eval_sched.md
Name: dtree_eval_sched

Overview:
- Sequencer in front of a combinational printed decision-tree classifier (pendigits-style: 16 features of 8 bits, 4-bit class).
- Collects one feature vector from a serial valid/ready stream into a feature register bank.
- Holds that bank stable on the tree's input bus for a fixed settling window, then captures the tree's class output.
- Presents the class on a valid/ready result port; the tree itself remains external and purely combinational.

Parameters:
- NUM_FEAT, 16, features per sample (≥2).
- FEAT_W, 8, bits per feature.
- CLASS_W, 4, class output width.
- SETTLE_CYC, 2, cycles the feature bus is held stable before capture (≥1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  feature beat valid.
- in_ready  output  1  scheduler can accept a beat.
- in_feat  input  FEAT_W  feature value; beat k carries feature index k.
- in_last  input  1  marks final beat of a sample.
- feat_bus  output  NUM_FEAT*FEAT_W  registered features to tree; feature k at bits [k*FEAT_W +: FEAT_W].
- tree_class  input  CLASS_W  combinational class from tree.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_class  output  CLASS_W  captured class.
- err_frame  output  1  one-cycle pulse on framing error.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, idx=0, feat_bus=0, out_valid=0, out_class=0, err_frame=0, settle counter=0, in_ready=1 the first cycle after release.
- States: LOAD, DISCARD, SETTLE, HOLD.
- LOAD:
  - in_ready=1; a beat transfers on in_valid&in_ready.
  - The transferred beat writes feat reg[idx] and idx increments.
  - Beat with idx==NUM_FEAT-1 and in_last=1: go to SETTLE, idx←0.
  - Beat with idx==NUM_FEAT-1 and in_last=0: write it, pulse err_frame, go to DISCARD, idx←0.
  - Beat with idx<NUM_FEAT-1 and in_last=1 (short frame): write it, pulse err_frame, idx←0, stay in LOAD. No result is produced; stale registers are overwritten by the next frame.
- DISCARD:
  - in_ready=1; beats are accepted and dropped.
  - A beat with in_last=1 returns to LOAD. No further err_frame pulses.
- SETTLE:
  - in_ready=0; feat_bus is held constant.
  - Counter runs 0..SETTLE_CYC-1.
  - On the cycle the counter equals SETTLE_CYC-1: out_class←tree_class, out_valid←1, go to HOLD.
  - Latency: last beat accepted at cycle T gives out_valid=1 at cycle T+1+SETTLE_CYC.
- HOLD:
  - in_ready=0; out_valid and out_class stay stable until out_ready=1.
  - On handshake: out_valid←0 next cycle, go to LOAD, in_ready=1 on that same next cycle.
  - No overlap between loading and result holding: exactly one sample is in flight.
- feat_bus is only ever written in LOAD. It keeps the last sample during DISCARD, SETTLE and HOLD.
- err_frame is registered: high for exactly one cycle, on the cycle after the offending beat.
- Reset asserted mid-operation (any state) aborts immediately to reset values. A partial frame or pending result is lost.
- in_valid while in_ready=0 has no effect. Upstream must hold its beat.
- idx width is clog2(NUM_FEAT). idx never exceeds NUM_FEAT-1.

Optional Feature:
- Macro: DTREE_EVAL_SCHED_STATS_EN.
- When defined, two extra outputs are added:
  - cnt_samples[15:0]: increments on each result handshake.
  - cnt_errors[15:0]: increments on each err_frame pulse.
- Both counters saturate at 16'hFFFF and reset to 0 asynchronously.
- When undefined, neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- Nominal frame: 16 beats (value 8'h10+k), in_last on beat 15, tree_class tied to 4'd7 → feat_bus feature k = 8'h10+k. out_valid rises exactly SETTLE_CYC+1 cycles after the last beat, with out_class=7. err_frame stays 0.
- Back-pressure: hold out_ready=0 for 10 cycles → out_valid and out_class stay stable, in_ready=0 throughout. After out_ready=1, in_ready=1 on the next cycle and a second frame of 16 beats classifies as 4'd3.
- Short frame: in_last on beat 5 → err_frame pulses once, no out_valid. The following 16-beat frame produces a correct result.
- Long frame: 20 beats with in_last on beat 19 → err_frame pulses once after beat 15, beats 16–19 are accepted and dropped, no out_valid. The next frame is normal.
- Reset mid-SETTLE: assert rst_n=0 during SETTLE → out_valid=0, feat_bus=0, in_ready=1 after release. A fresh frame completes normally.
- STATS_EN build: 3 good frames + 2 bad frames → cnt_samples=3, cnt_errors=2.
